// File: rtl/ddr2_port_arbiter_0_if.sv
// Requester, user-interface FIFO and read-return signals of the two-port
// DDR2 arbiter. slave = arbiter view, master = requester/controller view.
interface ddr2_port_arbiter_0_if #(
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
);
  logic              init_done;
  logic              req0_valid;
  logic              req1_valid;
  logic [35:0]       req0_addr;
  logic [35:0]       req1_addr;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req1_wdata;
  logic [MASK_W-1:0] req0_wmask;
  logic [MASK_W-1:0] req1_wmask;
  logic              req0_wd_ack;
  logic              req1_wd_ack;
  logic              rd0_valid;
  logic              rd1_valid;
  logic [DATA_W-1:0] rd_data;
  logic [35:0]       app_af_addr;
  logic              app_af_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_mask_data;
  logic              app_wdf_wren;
  logic              af_almost_full;
  logic              wdf_almost_full;
  logic              read_data_valid;
  logic [DATA_W-1:0] read_data_fifo_out;
  logic              rd_err;

  modport slave (
    input  init_done,
    input  req0_valid, req1_valid,
    input  req0_addr, req1_addr,
    output req0_ready, req1_ready,
    input  req0_wdata, req1_wdata,
    input  req0_wmask, req1_wmask,
    output req0_wd_ack, req1_wd_ack,
    output rd0_valid, rd1_valid, rd_data,
    output app_af_addr, app_af_wren,
    output app_wdf_data, app_mask_data,
    output app_wdf_wren,
    input  af_almost_full, wdf_almost_full,
    input  read_data_valid, read_data_fifo_out,
    output rd_err
  );

  modport master (
    output init_done,
    output req0_valid, req1_valid,
    output req0_addr, req1_addr,
    input  req0_ready, req1_ready,
    output req0_wdata, req1_wdata,
    output req0_wmask, req1_wmask,
    input  req0_wd_ack, req1_wd_ack,
    input  rd0_valid, rd1_valid, rd_data,
    input  app_af_addr, app_af_wren,
    input  app_wdf_data, app_mask_data,
    input  app_wdf_wren,
    output af_almost_full, wdf_almost_full,
    output read_data_valid, read_data_fifo_out,
    input  rd_err
  );
endinterface

// File: rtl/ddr2_port_arbiter_0.sv
// Two-port command/write-data arbiter for the DDR2 user interface, with a
// read tag FIFO steering returned beats back to the issuing port.
// Ports: clk, reset (sync, active-high), bus (ddr2_port_arbiter_0_if.slave).
// Build option: DDR2_ARB_FIXED_PRIO_EN -> port 0 always wins, no RR pointer.
module ddr2_port_arbiter_0 #(
  parameter int DATA_W    = 128,
  parameter int MASK_W    = 16,
  parameter int BEATS     = 2,
  parameter int TAG_DEPTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  ddr2_port_arbiter_0_if.slave bus
);
  localparam int         TW   = $clog2(TAG_DEPTH);
  localparam logic [1:0] LAST = 2'(BEATS - 1);
  localparam logic [TW:0] ONE = 1;
  localparam logic [TW:0] FULL = (TW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, WDATA} state_t;

  state_t            state_q, state_d;
  logic              wport_q, wport_d;
  logic [1:0]        beat_q, beat_d;
  logic [35:0]       af_addr_q;
  logic              af_wren_q;
  logic [DATA_W-1:0] wdf_data_q;
  logic [MASK_W-1:0] mask_q;
  logic              wdf_wren_q;
  logic [TW-1:0]     wptr_q, rptr_q;
  logic [TW:0]       cnt_q, cnt_d;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [1:0]        rbeat_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd0_q, rd1_q;
  logic              rd_err_q;

  logic wr0, wr1, base_ok;
  logic tag_full, tag_empty;
  logic elig0, elig1, pick1;
  logic idle, in_wd;
  logic gnt0, gnt1, gnt, gwr;
  logic [35:0] gaddr;
  logic push, pop, ret, head;

  assign wr0       = bus.req0_addr[34:32] == 3'b100;
  assign wr1       = bus.req1_addr[34:32] == 3'b100;
  assign tag_full  = cnt_q == FULL;
  assign tag_empty = cnt_q == '0;
  assign base_ok   = bus.init_done & ~bus.af_almost_full;

  assign elig0 = bus.req0_valid & base_ok &
                 (wr0 ? ~bus.wdf_almost_full : ~tag_full);
  assign elig1 = bus.req1_valid & base_ok &
                 (wr1 ? ~bus.wdf_almost_full : ~tag_full);

`ifdef DDR2_ARB_FIXED_PRIO_EN
  assign pick1 = ~elig0;
`else
  // last_q holds the port granted last; it loses a tie.
  logic last_q;
  assign pick1 = ~elig0 | (elig1 & ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (gnt) begin
      last_q <= gnt1;
    end
  end
`endif

  assign idle  = state_q == IDLE;
  assign in_wd = state_q == WDATA;
  assign gnt0  = idle & elig0 & ~pick1;
  assign gnt1  = idle & elig1 & pick1;
  assign gnt   = gnt0 | gnt1;
  assign gwr   = gnt1 ? wr1 : wr0;
  assign gaddr = gnt1 ? bus.req1_addr : bus.req0_addr;

  assign head = tag_q[rptr_q];
  assign push = gnt & ~gwr;
  assign ret  = bus.read_data_valid & ~tag_empty;
  assign pop  = ret & (rbeat_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wport_d = wport_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (gnt & gwr) begin
          state_d = WDATA;
          wport_d = gnt1;
          beat_d  = '0;
        end
      end
      WDATA: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == LAST) begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wport_q    <= 1'b0;
      beat_q     <= '0;
      af_addr_q  <= '0;
      af_wren_q  <= 1'b0;
      wdf_data_q <= '0;
      mask_q     <= '0;
      wdf_wren_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      rbeat_q    <= '0;
      rd_data_q  <= '0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wport_q    <= wport_d;
      beat_q     <= beat_d;
      af_wren_q  <= gnt;
      wdf_wren_q <= in_wd;
      cnt_q      <= cnt_d;
      rd0_q      <= ret & ~head;
      rd1_q      <= ret & head;
      if (gnt) begin
        af_addr_q <= gaddr;
      end
      if (in_wd) begin
        wdf_data_q <= wport_q ? bus.req1_wdata : bus.req0_wdata;
        mask_q     <= wport_q ? bus.req1_wmask : bus.req0_wmask;
      end
      if (push) begin
        tag_q[wptr_q] <= gnt1;
        wptr_q        <= wptr_q + TW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + TW'(1);
      end
      if (ret) begin
        rd_data_q <= bus.read_data_fifo_out;
        rbeat_q   <= (rbeat_q == LAST) ? 2'd0 : rbeat_q + 2'd1;
      end
      // Data with nothing outstanding is a controller protocol error.
      if (bus.read_data_valid & tag_empty) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  assign bus.req0_ready    = gnt0;
  assign bus.req1_ready    = gnt1;
  assign bus.req0_wd_ack   = in_wd & ~wport_q;
  assign bus.req1_wd_ack   = in_wd & wport_q;
  assign bus.app_af_addr   = af_addr_q;
  assign bus.app_af_wren   = af_wren_q;
  assign bus.app_wdf_data  = wdf_data_q;
  assign bus.app_mask_data = mask_q;
  assign bus.app_wdf_wren  = wdf_wren_q;
  assign bus.rd0_valid     = rd0_q;
  assign bus.rd1_valid     = rd1_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_err        = rd_err_q;
endmodule

// File: tb/tb_ddr2_port_arbiter_0.sv
// Bench for ddr2_port_arbiter_0: grant table plus hand sequences, with
// queues holding expected command, write-data and read-return strobes.
module tb_ddr2_port_arbiter_0;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int BEATS = 2;
  localparam int TD = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ddr2_port_arbiter_0_if #(.DATA_W(DW), .MASK_W(MW)) bus ();

  ddr2_port_arbiter_0 #(
    .DATA_W(DW), .MASK_W(MW), .BEATS(BEATS), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0]       af_q[$];
  logic [DW+MW-1:0]  wdf_q[$];
  logic [DW:0]       rd_q[$];
  logic              tag_m[$];
  int                rbeat_m = 0;

  typedef struct {
    logic init, v0, w0, v1, w1, afaf, wdfaf;
    logic [1:0] rr, fx;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: strobe with nothing expected", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk(input logic wr, input int n);
    return {1'b0, wr ? 3'b100 : 3'b101, 32'(n)};
  endfunction

  task automatic exp_grant(input logic p, input logic [35:0] a);
    af_q.push_back(a);
    if (a[34:32] != 3'b100) tag_m.push_back(p);
  endtask

  task automatic ret_beat(input logic [DW-1:0] d);
    bus.read_data_valid    = 1'b1;
    bus.read_data_fifo_out = d;
    if (tag_m.size() > 0) begin
      rd_q.push_back({tag_m[0], d});
      rbeat_m++;
      if (rbeat_m == BEATS) begin
        tag_m.delete(0);
        rbeat_m = 0;
      end
    end
  endtask

  task automatic drain(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      logic [1:0] oh;
      oh = (tag_m.size() == 0) ? 2'b00 : (tag_m[0] ? 2'b10 : 2'b01);
      ret_beat(base + DW'(k));
      tick();
      chk("rd_strobe", {bus.rd1_valid, bus.rd0_valid}, oh);
    end
    bus.read_data_valid = 1'b0;
  endtask

  logic [DW:0] mon_e;
  always @(negedge clk) begin
    if (bus.app_af_wren === 1'b1) begin
      if (af_q.size() == 0) unexp("af_wren");
      else chk("af_addr", bus.app_af_addr, af_q.pop_front());
    end
    if (bus.app_wdf_wren === 1'b1) begin
      if (wdf_q.size() == 0) unexp("wdf_wren");
      else chk("wdf_data", {bus.app_wdf_data, bus.app_mask_data},
               wdf_q.pop_front());
    end
    if (bus.rd0_valid === 1'b1 || bus.rd1_valid === 1'b1) begin
      if (rd_q.size() == 0) unexp("rd_valid");
      else begin
        mon_e = rd_q.pop_front();
        chk("rd_port", {bus.rd1_valid, bus.rd0_valid},
            mon_e[DW] ? 2'b10 : 2'b01);
        chk("rd_data", bus.rd_data, mon_e[DW-1:0]);
      end
    end
  end

  initial begin
    logic [1:0]  e;
    logic [35:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [MW-1:0] m0, m1;

    tbl[0] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00};
    tbl[1] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b01};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,2'b01};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b01};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,2'b01};
    tbl[5] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00};
    tbl[6] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,2'b10};
    tbl[7] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b01};
    tbl[8] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,2'b01,2'b01};
    tbl[9] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00};

    reset = 1'b1;
    bus.init_done = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_addr = '0;
    bus.req1_addr = '0;
    bus.req0_wdata = '0;
    bus.req1_wdata = '0;
    bus.req0_wmask = '0;
    bus.req1_wmask = '0;
    bus.af_almost_full = 1'b0;
    bus.wdf_almost_full = 1'b0;
    bus.read_data_valid = 1'b0;
    bus.read_data_fifo_out = '0;

    tick();
    tick();
    #2;
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("rst_ack", {bus.req1_wd_ack, bus.req0_wd_ack}, 2'b00);
    chk("rst_af", {bus.app_af_wren, bus.app_af_addr}, 37'd0);
    chk("rst_wdf", bus.app_wdf_wren, 1'b0);
    chk("rst_rd", {bus.rd1_valid, bus.rd0_valid, bus.rd_data}, '0);
    chk("rst_err", bus.rd_err, 1'b0);
    reset = 1'b0;
    tick();

    // Grant decisions: reads and blocked cases only, FSM stays IDLE.
    for (int i = 0; i < 10; i++) begin
      a0 = mk(tbl[i].w0, i);
      a1 = mk(tbl[i].w1, 32'h100 + i);
      bus.init_done = tbl[i].init;
      bus.req0_valid = tbl[i].v0;
      bus.req1_valid = tbl[i].v1;
      bus.req0_addr = a0;
      bus.req1_addr = a1;
      bus.af_almost_full = tbl[i].afaf;
      bus.wdf_almost_full = tbl[i].wdfaf;
      #2;
`ifdef DDR2_ARB_FIXED_PRIO_EN
      e = tbl[i].fx;
`else
      e = tbl[i].rr;
`endif
      chk($sformatf("tbl%0d_ready", i),
          {bus.req1_ready, bus.req0_ready}, e);
      if (e[0]) exp_grant(1'b0, a0);
      if (e[1]) exp_grant(1'b1, a1);
      tick();
      chk($sformatf("tbl%0d_afwren", i), bus.app_af_wren, |e);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.af_almost_full = 1'b0;
    bus.wdf_almost_full = 1'b0;
    tick();

    // Return all seven outstanding reads, one burst each.
    drain(14, 128'hD000);
    tick();

    // Read data with nothing outstanding.
    chk("err_before", bus.rd_err, 1'b0);
    drain(1, 128'hEEEE);
    tick();
    chk("err_set", bus.rd_err, 1'b1);
    tick();
    tick();
    chk("err_sticky", bus.rd_err, 1'b1);

    // Port 0 write burst while port 1 waits with a read.
    a0 = mk(1'b1, 32'h55);
    a1 = mk(1'b0, 32'h66);
    d0 = {4{32'hA0A0_0000}};
    d1 = {4{32'hA1A1_1111}};
    m0 = 16'h00F0;
    m1 = 16'h0F00;
    bus.req0_valid = 1'b1;
    bus.req0_addr = a0;
    #2;
    chk("wr_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
    exp_grant(1'b0, a0);
    tick();
    chk("wr_af_n1", bus.app_af_wren, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr = a1;
    bus.req0_wdata = d0;
    bus.req0_wmask = m0;
    #2;
    chk("wr_b0_ack", {bus.req1_wd_ack, bus.req0_wd_ack}, 2'b01);
    chk("wr_b0_rdy", bus.req1_ready, 1'b0);
    wdf_q.push_back({d0, m0});
    tick();
    chk("wr_wdf_n2", bus.app_wdf_wren, 1'b1);
    bus.req0_wdata = d1;
    bus.req0_wmask = m1;
    bus.wdf_almost_full = 1'b1;
    #2;
    chk("wr_b1_ack", {bus.req1_wd_ack, bus.req0_wd_ack}, 2'b01);
    chk("wr_b1_rdy", bus.req1_ready, 1'b0);
    wdf_q.push_back({d1, m1});
    tick();
    chk("wr_wdf_n3", bus.app_wdf_wren, 1'b1);
    bus.req0_wdata = '1;
    #2;
    chk("wr_n3_ack", {bus.req1_wd_ack, bus.req0_wd_ack}, 2'b00);
    chk("wr_n3_rdy", bus.req1_ready, 1'b1);
    exp_grant(1'b1, a1);
    tick();
    chk("wr_n4_wdf", bus.app_wdf_wren, 1'b0);
    bus.req1_valid = 1'b0;
    bus.wdf_almost_full = 1'b0;
    drain(2, 128'hF000);
    tick();

    // Fill the tag FIFO from port 1, then free one slot.
    for (int k = 0; k < TD; k++) begin
      a1 = mk(1'b0, 32'h200 + k);
      bus.req1_valid = 1'b1;
      bus.req1_addr = a1;
      #2;
      chk($sformatf("fill%0d_rdy", k), bus.req1_ready, 1'b1);
      exp_grant(1'b1, a1);
      tick();
    end
    a1 = mk(1'b0, 32'h300);
    bus.req1_addr = a1;
    #2;
    chk("full_stall0", bus.req1_ready, 1'b0);
    tick();
    ret_beat(128'hC000);
    #2;
    chk("full_stall1", bus.req1_ready, 1'b0);
    tick();
    chk("full_rd0", {bus.rd1_valid, bus.rd0_valid}, 2'b10);
    ret_beat(128'hC001);
    #2;
    chk("full_stall2", bus.req1_ready, 1'b0);
    tick();
    chk("full_rd1", {bus.rd1_valid, bus.rd0_valid}, 2'b10);
    bus.read_data_valid = 1'b0;
    #2;
    chk("full_regrant", bus.req1_ready, 1'b1);
    exp_grant(1'b1, a1);
    tick();
    bus.req1_valid = 1'b0;
    drain(2 * TD, 128'hB000);
    tick();

    // Reset in the middle of a write burst.
    a0 = mk(1'b1, 32'h77);
    bus.req0_valid = 1'b1;
    bus.req0_addr = a0;
    #2;
    chk("rw_ready", bus.req0_ready, 1'b1);
    exp_grant(1'b0, a0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_wdata = d0;
    bus.req0_wmask = m0;
    #2;
    chk("rw_b0_ack", bus.req0_wd_ack, 1'b1);
    wdf_q.push_back({d0, m0});
    tick();
    bus.req0_wdata = d1;
    reset = 1'b1;
    #2;
    chk("rw_b1_ack", bus.req0_wd_ack, 1'b1);
    tick();
    reset = 1'b0;
    a1 = mk(1'b0, 32'h88);
    bus.req1_valid = 1'b1;
    bus.req1_addr = a1;
    #2;
    chk("rw_wdf_off", bus.app_wdf_wren, 1'b0);
    chk("rw_ack_off", bus.req0_wd_ack, 1'b0);
    chk("rw_idle_rdy", bus.req1_ready, 1'b1);
    chk("rw_err_clr", bus.rd_err, 1'b0);
    exp_grant(1'b1, a1);
    tick();
    bus.req1_valid = 1'b0;
    drain(2, 128'h9000);
    tick();
    tick();
    tick();

    chk("af_q_empty", af_q.size(), 0);
    chk("wdf_q_empty", wdf_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("tag_m_empty", tag_m.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
